// File: rtl/cic_decimator_n.sv
// cic_decimator_n: N-order CIC decimation filter for a 1-bit sigma-delta bitstream.
//
// Chain: ORDER pipelined integrators run on every enabled input cycle. A frame
// counter marks the decimation event. On that event ORDER comb stages produce
// the decimated sample.
//
// The decimation factor R is sampled from decimation_i at each frame start and
// clamped to 2..MAX_DECIMATION. cfg_err_o flags a clamped frame.
//
// All datapath arithmetic is modulo 2^REGISTER_WIDTH. The CIC wrap property
// keeps the result exact when REGISTER_WIDTH >= ORDER*ceil(log2(MAX_DECIMATION))+1.
//
// Optional build macro:
//   CIC_DECIMATOR_DEBUG_TAP_EN - adds debug_sel_i / debug_tap_o. These expose a
//   registered copy of one integrator (sel 0..3) or one comb delay (sel 4..7).
//   A stage index at or above ORDER reads 0. The filter behaviour is identical
//   whether the macro is defined or not.

module cic_decimator_n #(
    parameter int ORDER          = 3,
    parameter int REGISTER_WIDTH = 24,
    parameter int MAX_DECIMATION = 64,
    parameter int DEC_WIDTH      = 7
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      enable_i,
    input  logic                      modulator_data_i,
    input  logic [DEC_WIDTH-1:0]      decimation_i,
`ifdef CIC_DECIMATOR_DEBUG_TAP_EN
    input  logic [2:0]                debug_sel_i,
    output logic [REGISTER_WIDTH-1:0] debug_tap_o,
`endif
    output logic [REGISTER_WIDTH-1:0] cic_data_o,
    output logic                      cic_valid_o,
    output logic                      cic_clk_o,
    output logic                      cfg_err_o
);

    localparam int W = REGISTER_WIDTH;
    localparam logic [DEC_WIDTH-1:0] MAX_DEC = DEC_WIDTH'(MAX_DECIMATION);
    localparam logic [DEC_WIDTH-1:0] MIN_DEC = DEC_WIDTH'(2);
    localparam logic [DEC_WIDTH-1:0] ONE_DEC = DEC_WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0]         integ_reg [ORDER];
    logic [W-1:0]         integ_next [ORDER];
    logic [W-1:0]         dly_reg [ORDER];
    logic [W-1:0]         comb_c [ORDER+1];

    logic [DEC_WIDTH-1:0] cnt_reg;
    logic [DEC_WIDTH-1:0] cnt_next;
    logic [DEC_WIDTH-1:0] r_act_reg;
    logic                 cfg_err_reg;

    logic [W-1:0]         data_reg;
    logic                 valid_reg;
    logic                 dclk_reg;

    // ------------------------------------------------------------------
    // Frame control signals
    // ------------------------------------------------------------------
    logic [DEC_WIDTH-1:0] r_clamped;
    logic                 clamp_err;
    logic                 frame_start;
    logic [DEC_WIDTH-1:0] r_eff;
    logic                 frame_last;
    logic                 dclk_next;
    logic                 dec_event;

    // Clamp the requested factor into the supported range 2..MAX_DECIMATION.
    always_comb begin
        r_clamped = decimation_i;
        clamp_err = 1'b0;
        if (decimation_i < MIN_DEC) begin
            r_clamped = MIN_DEC;
            clamp_err = 1'b1;
        end else if (decimation_i > MAX_DEC) begin
            r_clamped = MAX_DEC;
            clamp_err = 1'b1;
        end
    end

    // The factor loaded at frame start already governs the first cycle of the
    // frame. The counter wrap and the decimated clock therefore use it
    // immediately, not one cycle later.
    always_comb begin
        frame_start = (cnt_reg == '0);
        r_eff       = frame_start ? r_clamped : r_act_reg;
        frame_last  = (cnt_reg == (r_eff - ONE_DEC));
        cnt_next    = frame_last ? '0 : (cnt_reg + ONE_DEC);
        dclk_next   = (cnt_next < (r_eff >> 1));
        dec_event   = enable_i && frame_last;
    end

    // Integrator chain: each stage accumulates the previous stage's registered
    // value. This makes the chain pipelined, with no long carry path through
    // all stages.
    always_comb begin
        integ_next[0] = integ_reg[0] + W'(modulator_data_i);
        for (int k = 1; k < ORDER; k++) begin
            integ_next[k] = integ_reg[k] + integ_reg[k-1];
        end
    end

    // Comb chain: a combinational cascade of differences against the delays
    // captured at the previous decimation event.
    always_comb begin
        comb_c[0] = integ_reg[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            comb_c[k+1] = comb_c[k] - dly_reg[k];
        end
    end

    // Integrators advance on every enabled cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_reg[k] <= '0;
            end
        end else if (enable_i) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_reg[k] <= integ_next[k];
            end
        end
    end

    // Comb delays capture their stage inputs only on a decimation event.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < ORDER; k++) begin
                dly_reg[k] <= '0;
            end
        end else if (dec_event) begin
            for (int k = 0; k < ORDER; k++) begin
                dly_reg[k] <= comb_c[k];
            end
        end
    end

    // Frame counter, factor latch and decimated clock. All of these hold
    // while enable_i is low.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_reg     <= '0;
            r_act_reg   <= MAX_DEC;
            cfg_err_reg <= 1'b0;
            dclk_reg    <= 1'b0;
        end else if (enable_i) begin
            cnt_reg  <= cnt_next;
            dclk_reg <= dclk_next;
            if (frame_start) begin
                r_act_reg   <= r_clamped;
                cfg_err_reg <= clamp_err;
            end
        end
    end

    // Output sample and its one-cycle strobe. The strobe defaults low every
    // cycle, so a stalled event cycle cannot repeat a pulse.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (dec_event) begin
                data_reg  <= comb_c[ORDER];
                valid_reg <= 1'b1;
            end
        end
    end

    assign cic_data_o  = data_reg;
    assign cic_valid_o = valid_reg;
    assign cic_clk_o   = dclk_reg;
    assign cfg_err_o   = cfg_err_reg;

`ifdef CIC_DECIMATOR_DEBUG_TAP_EN
    // Debug tap: pad both stage arrays to four entries so that every selector
    // value is defined. Stages that do not exist read as zero.
    logic [W-1:0] int_pad [4];
    logic [W-1:0] dly_pad [4];
    logic [W-1:0] tap_next;
    logic [W-1:0] tap_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_tap_pad
        if (gi < ORDER) begin : g_live
            assign int_pad[gi] = integ_reg[gi];
            assign dly_pad[gi] = dly_reg[gi];
        end else begin : g_absent
            assign int_pad[gi] = '0;
            assign dly_pad[gi] = '0;
        end
    end

    // Select the tapped stage: bit 2 chooses the delays, the low bits the stage.
    always_comb begin
        tap_next = int_pad[debug_sel_i[1:0]];
        if (debug_sel_i[2]) begin
            tap_next = dly_pad[debug_sel_i[1:0]];
        end
    end

    // The tap register runs every cycle, independent of enable_i.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tap_reg <= '0;
        end else begin
            tap_reg <= tap_next;
        end
    end

    assign debug_tap_o = tap_reg;
`endif

endmodule

// File: tb/tb_cic_decimator_n.sv
// Directed bench for cic_decimator_n: three instances (ORDER 1, 2, 3) share the
// stimulus. Expected pulse gaps and data are hand-computed closed forms of the
// CIC response to a constant input, e.g. ORDER=2, R=10 gives 36, 99, 100, 100.
module tb_cic_decimator_n;

    localparam int W = 24;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          din;
    logic [6:0]    dec;
    logic [W-1:0]  d1, d2, d3;
    logic          v1, v2, v3;
    logic          c1, c2, c3;
    logic          e1, e2, e3;
`ifdef CIC_DECIMATOR_DEBUG_TAP_EN
    logic [2:0]    dsel;
    logic [W-1:0]  t1, t2, t3;
`endif

    int cmp_count  = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    cic_decimator_n #(.ORDER(1)) u1 (
        .clk_i(clk), .rstn_i(rstn), .enable_i(en), .modulator_data_i(din),
        .decimation_i(dec),
`ifdef CIC_DECIMATOR_DEBUG_TAP_EN
        .debug_sel_i(dsel), .debug_tap_o(t1),
`endif
        .cic_data_o(d1), .cic_valid_o(v1), .cic_clk_o(c1), .cfg_err_o(e1)
    );

    cic_decimator_n #(.ORDER(2)) u2 (
        .clk_i(clk), .rstn_i(rstn), .enable_i(en), .modulator_data_i(din),
        .decimation_i(dec),
`ifdef CIC_DECIMATOR_DEBUG_TAP_EN
        .debug_sel_i(dsel), .debug_tap_o(t2),
`endif
        .cic_data_o(d2), .cic_valid_o(v2), .cic_clk_o(c2), .cfg_err_o(e2)
    );

    cic_decimator_n #(.ORDER(3)) u3 (
        .clk_i(clk), .rstn_i(rstn), .enable_i(en), .modulator_data_i(din),
        .decimation_i(dec),
`ifdef CIC_DECIMATOR_DEBUG_TAP_EN
        .debug_sel_i(dsel), .debug_tap_o(t3),
`endif
        .cic_data_o(d3), .cic_valid_o(v3), .cic_clk_o(c3), .cfg_err_o(e3)
    );

    typedef struct {
        bit rst;        // reset before applying this record
        int sel;        // which instance (its ORDER) to observe
        int dec;        // decimation_i
        bit din;        // modulator bit held constant
        int stall_at;   // enabled cycles into the frame before the stall (-1: none)
        int stall_len;  // disabled cycles inserted
        int exp_gap;    // enabled cycles since previous pulse (or reset release)
        int exp_data;
        bit exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic get_v(input int sel);
        case (sel)
            1: return v1;
            2: return v2;
            default: return v3;
        endcase
    endfunction

    function automatic logic [W-1:0] get_d(input int sel);
        case (sel)
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    function automatic logic get_c(input int sel);
        case (sel)
            1: return c1;
            2: return c2;
            default: return c3;
        endcase
    endfunction

    function automatic logic get_e(input int sel);
        case (sel)
            1: return e1;
            2: return e2;
            default: return e3;
        endcase
    endfunction

    task automatic add_vec(input bit rst, input int sel, input int dv, input bit b,
                           input int sat, input int slen, input int gap,
                           input int data, input bit err);
        vec_t v;
        v.rst = rst; v.sel = sel; v.dec = dv; v.din = b;
        v.stall_at = sat; v.stall_len = slen;
        v.exp_gap = gap; v.exp_data = data; v.exp_err = err;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        cmp_count++;
        if (act != exp) begin
            fail_count++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over two edges, check the cleared state, release on a falling edge.
    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data1", d1, 0);
        check("rst_data3", d3, 0);
        check("rst_valid2", v2, 0);
        check("rst_clk1", c1, 0);
        check("rst_err1", e1, 0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Run until instance sel pulses, counting enabled edges. An optional stall is
    // inserted once stall_at enabled edges have elapsed in this frame.
    task automatic run_to_pulse(input int sel, input int stall_at, input int stall_len,
                                output int gap, output logic [W-1:0] dat,
                                output logic err);
        bit stalled = 0;
        bit timed_out = 1;
        logic held_clk;
        logic [W-1:0] held_data;
        gap = 0;
        dat = '0;
        err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!stalled && stall_at >= 0 && gap == stall_at) begin
                stalled = 1;
                held_clk = get_c(sel);
                held_data = get_d(sel);
                en = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    check("stall_valid", get_v(sel), 0);
                    check("stall_clk_hold", get_c(sel), held_clk);
                    check("stall_data_hold", get_d(sel), held_data);
                end
                en = 1'b1;
            end
            step();
            gap++;
            if (get_v(sel)) begin
                dat = get_d(sel);
                err = get_e(sel);
                timed_out = 0;
                break;
            end
        end
        check("pulse_timeout", timed_out, 0);
    endtask

    initial begin
        int gap;
        logic [W-1:0] dat;
        logic err;

        rstn = 1'b0;
        en   = 1'b1;
        din  = 1'b0;
        dec  = 7'd10;
`ifdef CIC_DECIMATOR_DEBUG_TAP_EN
        dsel = 3'd0;
`endif

        //      rst sel dec din stall len gap data err
        add_vec(1, 1, 10, 1, -1, 0, 10,   9, 0);
        add_vec(0, 1, 10, 1, -1, 0, 10,  10, 0);
        add_vec(0, 1, 10, 1, -1, 0, 10,  10, 0);
        add_vec(1, 2, 10, 1,  3, 7, 10,  36, 0);
        add_vec(0, 2, 10, 1,  9, 3, 10,  99, 0);
        add_vec(0, 2, 10, 1, -1, 0, 10, 100, 0);
        add_vec(0, 2, 10, 1, -1, 0, 10, 100, 0);
        add_vec(1, 3,  8, 1, -1, 0,  8,  35, 0);
        add_vec(0, 3,  8, 1, -1, 0,  8, 350, 0);
        add_vec(0, 3,  8, 1, -1, 0,  8, 511, 0);
        add_vec(0, 3,  8, 1, -1, 0,  8, 512, 0);
        add_vec(0, 3,  8, 1, -1, 0,  8, 512, 0);
        add_vec(1, 3,  8, 0, -1, 0,  8,   0, 0);
        add_vec(0, 3,  8, 0, -1, 0,  8,   0, 0);
        add_vec(1, 1,  1, 1, -1, 0,  2,   1, 1);
        add_vec(0, 1,  1, 1, -1, 0,  2,   2, 1);
        add_vec(0, 1, 100, 1, -1, 0, 64, 64, 1);
        add_vec(0, 1,  2, 1, -1, 0,  2,   2, 0);
        add_vec(0, 1, 64, 1, -1, 0, 64,  64, 0);

        foreach (vecs[i]) begin
            dec = 7'(vecs[i].dec);
            din = vecs[i].din;
            en  = 1'b1;
            if (vecs[i].rst) do_reset();
            run_to_pulse(vecs[i].sel, vecs[i].stall_at, vecs[i].stall_len, gap, dat, err);
            $display("vec %0d: order %0d dec %0d -> gap %0d data %0d err %0d",
                     i, vecs[i].sel, vecs[i].dec, gap, dat, err);
            check($sformatf("v%0d_gap", i), gap, vecs[i].exp_gap);
            check($sformatf("v%0d_data", i), dat, vecs[i].exp_data);
            check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
        end

        // Decimated clock and strobe shape, ORDER=1, R=10: high for cnt_next 0..4.
        dec = 7'd10; din = 1'b1; en = 1'b1;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step();
            check($sformatf("dclk_%0d", i), c1, ((i + 1) % 10) < 5);
            check($sformatf("dvalid_%0d", i), v1, (i % 10) == 9);
        end
        $display("seq dclk: 30 cycles checked");

        // Factor change at cnt=4 is deferred: this frame stays 10, the next is 16.
        dec = 7'd10;
        do_reset();
        repeat (4) step();
        dec = 7'd16;
        run_to_pulse(1, -1, 0, gap, dat, err);
        check("chg_gap0", gap, 6);
        check("chg_data0", dat, 9);
        run_to_pulse(1, -1, 0, gap, dat, err);
        check("chg_gap1", gap, 16);
        check("chg_data1", dat, 16);
        $display("seq dec change: gap %0d data %0d", gap, dat);

        // Asynchronous reset at cnt=6 clears outputs before the next edge.
        dec = 7'd10;
        do_reset();
        run_to_pulse(1, -1, 0, gap, dat, err);
        repeat (6) step();
        check("arst_pre_data1", d1, 9);
        rstn = 1'b0;
        #2;
        check("arst_data1", d1, 0);
        check("arst_data3", d3, 0);
        check("arst_valid1", v1, 0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        run_to_pulse(1, -1, 0, gap, dat, err);
        check("arst_gap", gap, 10);
        check("arst_data", dat, 9);
        $display("seq async reset: gap %0d data %0d", gap, dat);

`ifdef CIC_DECIMATOR_DEBUG_TAP_EN
        // ORDER=2 tap on int[1]: after edge i it holds C(i,2).
        dsel = 3'd1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("tap_int1_%0d", i), t2, (i * (i - 1)) / 2);
        end
        dsel = 3'd3;
        step();
        check("tap_absent", t2, 0);
        $display("seq debug tap: done");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule

// File: doc/cic_decimator_n.md
# cic_decimator_n

Parametrised N-order CIC decimation filter for a 1-bit sigma-delta bitstream. It generalises the fixed first- and second-order CIC blocks, adding:
- compile-time order 1..4;
- runtime-programmable decimation factor with clamping;
- clock-enable;
- a one-cycle output-valid strobe alongside the decimated clock.

It sits between the modulator input pin and the top-level debug/output multiplexer.

## Interface
Parameters:
- ORDER, 3, number of integrator and comb stages; legal 1..4.
- REGISTER_WIDTH, 24, width of every integrator, comb and output register; must be ≥ ORDER*ceil(log2(MAX_DECIMATION))+1.
- MAX_DECIMATION, 64, largest accepted decimation factor.
- DEC_WIDTH, 7, width of decimation_i; must hold MAX_DECIMATION.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- enable_i  input  1  clock-enable; low freezes all state.
- modulator_data_i  input  1  bitstream sample; 1 adds +1, 0 adds 0.
- decimation_i  input  DEC_WIDTH  requested decimation factor R.
- cic_data_o  output  REGISTER_WIDTH  last decimated result, unsigned, modulo 2^REGISTER_WIDTH.
- cic_valid_o  output  1  one-cycle pulse when cic_data_o updates.
- cic_clk_o  output  1  decimated clock, period R enabled cycles.
- cfg_err_o  output  1  high while the active R was clamped.

## Operation
- All arithmetic is REGISTER_WIDTH bits with wrap-around, with no saturation. Wrap is correct by CIC modulo property when the width rule holds.
- Frame counter cnt runs 0..R_act-1 and advances only when enable_i=1.
- R_act is loaded from decimation_i in every enabled cycle with cnt==0, and applies to that frame. Changes to decimation_i mid-frame are ignored until the next frame start.
- Clamp rule: decimation_i<2 gives R_act=2; decimation_i>MAX_DECIMATION gives R_act=MAX_DECIMATION. cfg_err_o is registered with R_act and is 1 if the loaded value was clamped, else 0.
- Integrators update each enabled cycle, using previous-cycle values so the chain is pipelined:
  - int[0] += modulator_data_i
  - int[k] += int[k-1] for k=1..ORDER-1
- Decimation event: an enabled cycle with cnt==R_act-1. On that cycle:
  - c[0] = int[ORDER-1]
  - c[k+1] = c[k] - dly[k] for k=0..ORDER-1 (combinational chain)
  - dly[k] <= c[k]
  - cic_data_o <= c[ORDER]
  - cic_valid_o <= 1
- cic_valid_o is 0 in every other cycle, including cycles with enable_i=0.
- cic_clk_o <= (cnt_next < R_act/2) on enabled cycles, using floor division. It holds its value when disabled.
- Steady-state gain for constant input 1 is R^ORDER.

## Timing
- Reset (asynchronous assert, synchronous-to-clk_i release): clears every integrator, delay, cic_data_o, cic_valid_o, cic_clk_o, cfg_err_o and cnt to 0, and sets R_act to MAX_DECIMATION.
- First enabled cycle after reset is cnt==0, so R_act is loaded from decimation_i.
- Reset asserted mid-frame discards the partial frame. No valid pulse is issued.
- Latency: cic_valid_o and the new cic_data_o appear together, one cycle after the decimation-event edge.
- Valid pulses are exactly R_act enabled cycles apart.
- The integrator pipeline adds ORDER-1 cycles of group delay before an input bit reaches c[0].
- enable_i low on the cycle that would be the decimation event defers the event until the next enabled cycle. No output is lost or duplicated.
- The frame-start load and the decimation event coincide when R_act==... impossible, since R_act≥2 guarantees cnt 0 and R_act-1 differ.

## Configuration
- Macro CIC_DECIMATOR_DEBUG_TAP_EN.
- Defined:
  - adds input debug_sel_i (3 bits) and output debug_tap_o (REGISTER_WIDTH bits, registered, reset 0).
  - debug_sel_i 0..3 selects int[sel]; 4..7 selects dly[sel-4].
  - A stage index ≥ ORDER yields 0.
  - The tap updates every cycle regardless of enable_i.
- Undefined: both ports are absent and no tap registers are synthesised. Filter behaviour is identical in both builds.

## Test plan
- ORDER=1, R=10, modulator_data_i constant 1: every cic_valid_o pulse after the first carries 10, pulses exactly 10 cycles apart, cic_clk_o high 5 and low 5 cycles.
- ORDER=2, R=10, constant 1: output settles to 100 by the third valid pulse. ORDER=3, R=8: output settles to 512. Constant 0 yields 0 throughout.
- decimation_i=1 then 200, with MAX_DECIMATION=64: R_act is 2 then 64, with cfg_err_o=1 in both cases. decimation_i changed from 10 to 16 at cnt=4: the current frame stays 10 cycles and the next is 16.
- Toggle enable_i low for 7 cycles mid-frame with ORDER=2, R=10: outputs and pulse spacing in enabled cycles match the unstalled reference model, and cic_valid_o is never high while stalled.
- Assert rstn_i for 1 cycle at cnt=6: all outputs go to 0 immediately (asynchronously). Next valid pulse arrives R_act enabled cycles after release.
- With CIC_DECIMATOR_DEBUG_TAP_EN, ORDER=2: debug_sel_i=1 tracks int[1] one cycle delayed, and debug_sel_i=3 reads 0.
